cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single CDB write port of the reorder buffer between N_REQ result producers (ALU, LSB load path, branch unit).
- Each producer pushes (RoB index, data) results into its own small FIFO.
- Every cycle the block grants at most one FIFO head round-robin and drives the registered CDB_update_* bus consumed by the RoB and the reservation stations.
- A flush from the RoB discards all buffered results.

Parameters:
- RoB_WIDTH, 3, width of the RoB entry index.
- N_REQ, 3, number of requesters (1..4); requester 0 = ALU, 1 = LSB, 2 = branch unit.
- FIFO_WIDTH, 1, log2 of per-requester FIFO depth.
- FIFO_DEPTH, 1 << FIFO_WIDTH, entries per requester FIFO.

Ports:
- clk_in  input  1  single clock; all state changes on its rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global enable; low = pause.
- flush_signal  input  1  RoB misprediction flush, synchronous.
- req_valid  input  N_REQ  per-requester result valid.
- req_index  input  N_REQ*RoB_WIDTH  RoB index; requester i occupies bits [i*RoB_WIDTH +: RoB_WIDTH].
- req_data  input  N_REQ*32  result data; requester i occupies [i*32 +: 32].
- req_ready  output  N_REQ  requester i may push this cycle.
- CDB_update_en  output  1  broadcast valid (registered).
- CDB_update_index  output  RoB_WIDTH  broadcast RoB index (registered).
- CDB_update_data  output  32  broadcast data (registered).
- CDB_update_src  output  2  requester number of the current broadcast (registered).

Behaviour:
- Reset (rst_in = 0, asynchronous):
  - all FIFO pointers and counts = 0, rr_ptr = 0;
  - CDB_update_en = 0, CDB_update_index = 0, CDB_update_data = 0, CDB_update_src = 0.
- req_ready[i]: combinational, = rdy_in && !flush_signal && count[i] < FIFO_DEPTH.
  - Depends only on registered state, never on the same-cycle pop.
- Push: on an edge where req_valid[i] && req_ready[i], write {index, data} at wr_ptr[i] and increment wr_ptr[i] (wraps mod FIFO_DEPTH).
  - req_valid while not ready: result ignored; the requester must hold it.
- Arbitration (combinational, from FIFO heads at the start of the cycle):
  - candidates are the requesters with count > 0;
  - scan starts at rr_ptr and wraps upward; the first candidate, k, is granted.
- Grant of k at an edge:
  - CDB_update_en <= 1, CDB_update_index/CDB_update_data <= head of FIFO k, CDB_update_src <= k;
  - rd_ptr[k]++;
  - rr_ptr <= (k+1) mod N_REQ.
- No candidate: CDB_update_en <= 0; index, data and src hold their values; rr_ptr holds.
- Simultaneous push and pop on the same FIFO: count unchanged, both pointers advance.
  - A push into an empty FIFO is not visible to arbitration until the next cycle.
- Latency: valid accepted at edge E0 → broadcast registered at edge E1 at the earliest; CDB_update_en is high during the cycle after E1.
  - Throughput: 1 broadcast per cycle in total.
- Fairness: with all requesters continuously non-empty, grants rotate 0, 1, 2, 0, …; no requester waits more than N_REQ-1 grants.
- flush_signal = 1 (and rdy_in = 1) at an edge:
  - all counts and pointers <= 0, rr_ptr <= 0, CDB_update_en <= 0;
  - no push and no grant in that cycle.
  - Flush takes priority over push and grant.
- rdy_in = 0:
  - no push, no grant, flush ignored;
  - CDB_update_en <= 0; every other register holds.
- rst_in asserted mid-operation: immediate clear per Reset, regardless of the clock.
- Entries for different RoB indices are independent; the arbiter never inspects or deduplicates index values.

Decomposition:
- Shared package / header: RoB_WIDTH, requester IDs (REQ_ALU = 0, REQ_LSB = 1, REQ_BRU = 2), CDB payload width (RoB_WIDTH + 32).
- One sub-module: cdb_req_fifo (parameterised FIFO_WIDTH; push/pop/flush; count, head outs), instantiated N_REQ times via generate.
- The round-robin pick stays in the top module.

Test Plan:
- Reset/idle: hold rst_in = 0, then release with no valids → CDB_update_en = 0 forever, req_ready = 3'b111.
- Single result: ALU pushes index 5, data 0x0000_1234 at edge E0 → after E1, CDB_update_en = 1, index 5, data 0x1234, src 0 for exactly one cycle.
- Contention: all three push in the same cycle (indices 1, 2, 3) → broadcasts in the next three cycles: index 1 (src 0), index 2 (src 1), index 3 (src 2); rr_ptr back to 0.
- Backpressure: LSB pushes 3 results with FIFO_DEPTH = 2 while ALU saturates the bus → req_ready[1] drops after 2 accepted; the 3rd is accepted only after the first LSB pop; all 3 broadcast in order, none lost or duplicated.
- Flush: 2 results buffered in each FIFO, flush_signal pulsed for one cycle → CDB_update_en = 0 the next cycle, all counts 0, a new ALU push of index 7 is broadcast 2 edges later with src 0.
- Pause: rdy_in = 0 for 4 cycles with FIFOs non-empty → no broadcasts and req_ready = 0; after rdy_in returns to 1, the grant order resumes from the saved rr_ptr.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the CDB arbiter: RoB index width, requester IDs, payload width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cdb_arbiter_pkg;

    localparam int ROB_W      = 3;
    localparam int DATA_W     = 32;
    localparam int PAYLOAD_W  = ROB_W + DATA_W;

    localparam int N_REQ_DEF      = 3;
    localparam int FIFO_WIDTH_DEF = 1;

    // Requester numbering as seen on CDB_update_src
    localparam logic [1:0] REQ_ALU = 2'd0;
    localparam logic [1:0] REQ_LSB = 2'd1;
    localparam logic [1:0] REQ_BRU = 2'd2;

endpackage

// File: rtl/cdb_req_fifo.sv
// Per-requester result FIFO holding {RoB index, data}; exposes head and occupancy.
// Latency: a push becomes visible on head/count after the writing edge.
// Backpressure: caller must not push when full nor pop when empty; flush clears it.
module cdb_req_fifo #(
    parameter int FIFO_WIDTH = 1,
    parameter int DATA_W     = 35
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    input  logic [DATA_W-1:0]     push_dat_i,
    output logic [FIFO_WIDTH:0]   count_o,
    output logic [DATA_W-1:0]     head_o
);
    localparam int DEPTH = 1 << FIFO_WIDTH;
    localparam logic [FIFO_WIDTH-1:0] PTR_ONE = 1;
    localparam logic [FIFO_WIDTH:0]   CNT_ONE = 1;

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [FIFO_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_WIDTH:0]   count_q, count_d;

    // Pointer/count next state; flush wins over any push or pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push_i && !pop_i)      count_d = count_q + CNT_ONE;
            else if (pop_i && !push_i) count_d = count_q - CNT_ONE;
        end
    end

    // Pointer/count registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read when count says they are valid
    always_ff @(posedge clk_in) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the single CDB write port among N_REQ result FIFOs.
// Latency: result accepted at edge E0 is broadcast (registered) at edge E1 at the earliest.
// Backpressure: req_ready per requester from registered occupancy; rdy_in low pauses all.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int RoB_WIDTH  = ROB_W,
    parameter int N_REQ      = N_REQ_DEF,
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int FIFO_DEPTH = 1 << FIFO_WIDTH
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        rdy_in,
    input  logic                        flush_signal,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*RoB_WIDTH-1:0]  req_index,
    input  logic [N_REQ*32-1:0]         req_data,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        CDB_update_en,
    output logic [RoB_WIDTH-1:0]        CDB_update_index,
    output logic [31:0]                 CDB_update_data,
    output logic [1:0]                  CDB_update_src
);
    localparam int PW = RoB_WIDTH + 32;
    localparam logic [FIFO_WIDTH:0] DEPTH_C = (FIFO_WIDTH+1)'(FIFO_DEPTH);

    logic                 run;
    logic                 flush_act;
    logic [FIFO_WIDTH:0]  count [N_REQ];
    logic [PW-1:0]        head  [N_REQ];
    logic [N_REQ-1:0]     push, pop, nonempty;

    logic                 grant_vld;
    logic [1:0]           grant_id;
    logic [PW-1:0]        grant_pay;

    logic                 en_q,  en_d;
    logic [RoB_WIDTH-1:0] idx_q, idx_d;
    logic [31:0]          dat_q, dat_d;
    logic [1:0]           src_q, src_d;
    logic [1:0]           rr_q,  rr_d;

    // Pause blocks everything; flush only acts while not paused
    assign run       = rdy_in && !flush_signal;
    assign flush_act = rdy_in && flush_signal;

    for (genvar g = 0; g < N_REQ; g++) begin : g_req
        assign req_ready[g] = run && (count[g] < DEPTH_C);
        assign push[g]      = req_valid[g] && req_ready[g];
        assign nonempty[g]  = (count[g] != '0);

        cdb_req_fifo #(
            .FIFO_WIDTH (FIFO_WIDTH),
            .DATA_W     (PW)
        ) u_fifo (
            .clk_in     (clk_in),
            .rst_in     (rst_in),
            .push_i     (push[g]),
            .pop_i      (pop[g]),
            .flush_i    (flush_act),
            .push_dat_i ({req_index[g*RoB_WIDTH +: RoB_WIDTH], req_data[g*32 +: 32]}),
            .count_o    (count[g]),
            .head_o     (head[g])
        );
    end

    // Round-robin pick: first non-empty FIFO scanning upward from rr_q with wrap
    always_comb begin
        int cand;
        cand      = 0;
        grant_vld = 1'b0;
        grant_id  = '0;
        grant_pay = '0;
        pop       = '0;
        for (int o = 0; o < N_REQ; o++) begin
            cand = int'(rr_q) + o;
            if (cand >= N_REQ) cand = cand - N_REQ;
            for (int j = 0; j < N_REQ; j++) begin
                if (!grant_vld && cand == j && nonempty[j]) begin
                    grant_vld = 1'b1;
                    grant_id  = 2'(j);
                    grant_pay = head[j];
                end
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            pop[j] = run && grant_vld && (grant_id == 2'(j));
        end
    end

    // Broadcast bus and rotation pointer next state
    always_comb begin
        en_d  = 1'b0;
        idx_d = idx_q;
        dat_d = dat_q;
        src_d = src_q;
        rr_d  = rr_q;
        if (flush_act) begin
            rr_d = '0;
        end else if (run && grant_vld) begin
            en_d  = 1'b1;
            idx_d = grant_pay[PW-1 -: RoB_WIDTH];
            dat_d = grant_pay[31:0];
            src_d = grant_id;
            rr_d  = (grant_id == 2'(N_REQ-1)) ? 2'd0 : grant_id + 2'd1;
        end
    end

    // Broadcast and arbitration state registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            en_q  <= 1'b0;
            idx_q <= '0;
            dat_q <= '0;
            src_q <= '0;
            rr_q  <= '0;
        end else begin
            en_q  <= en_d;
            idx_q <= idx_d;
            dat_q <= dat_d;
            src_q <= src_d;
            rr_q  <= rr_d;
        end
    end

    assign CDB_update_en    = en_q;
    assign CDB_update_index = idx_q;
    assign CDB_update_data  = dat_q;
    assign CDB_update_src   = src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter against a queue-based reference model.
// Latency: n/a.
// Backpressure: drivers hold each result until req_ready is seen high.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int RW = 3;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [RW-1:0] idx;
        logic [31:0]   dat;
    } ent_t;

    typedef struct {
        int          stamp;
        logic [RW-1:0] idx;
        logic [31:0] dat;
        logic [1:0]  src;
    } bc_t;

    logic            clk = 1'b0;
    logic            rst_in;
    logic            rdy_in;
    logic            flush_signal;
    logic [N-1:0]    req_valid;
    logic [N*RW-1:0] req_index;
    logic [N*32-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            CDB_update_en;
    logic [RW-1:0]   CDB_update_index;
    logic [31:0]     CDB_update_data;
    logic [1:0]      CDB_update_src;

    int total = 0;
    int bad   = 0;
    int cyc_cnt = 0;
    bit mon_on = 1'b0;

    cdb_arbiter #(.RoB_WIDTH(RW), .N_REQ(N), .FIFO_WIDTH(1), .FIFO_DEPTH(DEPTH)) dut (
        .clk_in           (clk),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .flush_signal     (flush_signal),
        .req_valid        (req_valid),
        .req_index        (req_index),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .CDB_update_en    (CDB_update_en),
        .CDB_update_index (CDB_update_index),
        .CDB_update_data  (CDB_update_data),
        .CDB_update_src   (CDB_update_src)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    // ---------------- reference model ----------------
    ent_t        mq [N][$];
    int          m_rr;
    logic        m_en;
    logic [RW-1:0] m_idx;
    logic [31:0] m_dat;
    logic [1:0]  m_src;
    int          k_m;
    ent_t        e_m;
    logic [N-1:0] acc_m;

    always @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_rr = 0; m_en = 0; m_idx = 0; m_dat = 0; m_src = 0;
        end else if (!rdy_in) begin
            m_en = 0;
        end else if (flush_signal) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_rr = 0; m_en = 0;
        end else begin
            for (int i = 0; i < N; i++) acc_m[i] = req_valid[i] && (mq[i].size() < DEPTH);
            k_m = -1;
            for (int o = 0; o < N; o++)
                if (k_m < 0 && mq[(m_rr + o) % N].size() > 0) k_m = (m_rr + o) % N;
            if (k_m >= 0) begin
                e_m   = mq[k_m].pop_front();
                m_en  = 1; m_idx = e_m.idx; m_dat = e_m.dat; m_src = 2'(k_m);
                m_rr  = (k_m + 1) % N;
            end else begin
                m_en = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (acc_m[i]) begin
                    e_m.idx = req_index[i*RW +: RW];
                    e_m.dat = req_data[i*32 +: 32];
                    mq[i].push_back(e_m);
                end
            end
        end
    end

    // ---------------- continuous monitor against the model ----------------
    bc_t bc_log[$];
    logic [N-1:0] exp_rdy;

    always @(negedge clk) begin
        if (mon_on && rst_in) begin
            for (int i = 0; i < N; i++)
                exp_rdy[i] = rdy_in && !flush_signal && (mq[i].size() < DEPTH);
            total++;
            if (req_ready !== exp_rdy) begin
                bad++;
                $display("FAIL mon_ready t=%0t got=%b exp=%b", $time, req_ready, exp_rdy);
            end
            total++;
            if (CDB_update_en !== m_en) begin
                bad++;
                $display("FAIL mon_en t=%0t got=%b exp=%b", $time, CDB_update_en, m_en);
            end
            if (m_en) begin
                total++;
                if ({CDB_update_index, CDB_update_data, CDB_update_src} !== {m_idx, m_dat, m_src}) begin
                    bad++;
                    $display("FAIL mon_bus t=%0t got=%0d/%h/%0d exp=%0d/%h/%0d", $time,
                             CDB_update_index, CDB_update_data, CDB_update_src, m_idx, m_dat, m_src);
                end
            end
            if (CDB_update_en === 1'b1)
                bc_log.push_back('{cyc_cnt, CDB_update_index, CDB_update_data, CDB_update_src});
        end
    end

    // ---------------- stimulus helpers (no checking) ----------------
    ent_t pend [N][$];
    int   rdy1_log[$];
    int   acc1_log[$];

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b0; rdy_in = 1'b1; flush_signal = 1'b0;
        req_valid = '0; req_index = '0; req_data = '0;
        for (int i = 0; i < N; i++) pend[i].delete();
        cyc();
        rst_in = 1'b1;
        bc_log.delete(); rdy1_log.delete(); acc1_log.delete();
    endtask

    task automatic pump(input int ncyc);
        logic [N-1:0] acc;
        for (int c = 0; c < ncyc; c++) begin
            for (int i = 0; i < N; i++) begin
                if (pend[i].size() > 0) begin
                    req_valid[i] = 1'b1;
                    req_index[i*RW +: RW] = pend[i][0].idx;
                    req_data[i*32 +: 32]  = pend[i][0].dat;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
            @(negedge clk);
            acc = req_valid & req_ready;
            rdy1_log.push_back(int'(req_ready[1]));
            if (acc[1]) acc1_log.push_back(cyc_cnt);
            cyc();
            for (int i = 0; i < N; i++) if (acc[i]) void'(pend[i].pop_front());
        end
        req_valid = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_in = 1'b0; rdy_in = 1'b1; flush_signal = 1'b0;
        req_valid = '0; req_index = '0; req_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (CDB_update_en !== 1'b0) begin bad++; $display("FAIL rst_en got=%b exp=0", CDB_update_en); end
        total++; if (CDB_update_index !== '0) begin bad++; $display("FAIL rst_idx got=%0d exp=0", CDB_update_index); end
        total++; if (CDB_update_data !== '0) begin bad++; $display("FAIL rst_dat got=%h exp=0", CDB_update_data); end
        total++; if (CDB_update_src !== '0) begin bad++; $display("FAIL rst_src got=%0d exp=0", CDB_update_src); end
        cyc();
        rst_in = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++; if (CDB_update_en !== 1'b0) begin bad++; $display("FAIL idle_en c=%0d got=%b exp=0", c, CDB_update_en); end
            total++; if (req_ready !== 3'b111) begin bad++; $display("FAIL idle_ready c=%0d got=%b exp=111", c, req_ready); end
            cyc();
        end
    endtask

    task automatic test_single();
        int s;
        do_reset();
        pend[0].push_back('{3'd5, 32'h0000_1234});
        s = cyc_cnt;
        pump(5);
        total++;
        if (bc_log.size() != 1) begin
            bad++; $display("FAIL single_count got=%0d exp=1", bc_log.size());
        end else begin
            total++;
            if (bc_log[0].stamp != s + 2 || bc_log[0].idx !== 3'd5 || bc_log[0].dat !== 32'h1234 || bc_log[0].src !== REQ_ALU) begin
                bad++;
                $display("FAIL single_bus got=cyc%0d/%0d/%h/%0d exp=cyc%0d/5/1234/0", bc_log[0].stamp - s,
                         bc_log[0].idx, bc_log[0].dat, bc_log[0].src, 2);
            end
        end
    endtask

    task automatic test_contention();
        int s;
        logic [31:0] d [N];
        do_reset();
        for (int i = 0; i < N; i++) begin
            d[i] = $urandom;
            pend[i].push_back('{3'(i + 1), d[i]});
        end
        s = cyc_cnt;
        pump(6);
        total++;
        if (bc_log.size() != 3) begin
            bad++; $display("FAIL cont_count got=%0d exp=3", bc_log.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if (bc_log[k].stamp != s + 2 + k || bc_log[k].idx !== 3'(k + 1) || bc_log[k].src !== 2'(k) || bc_log[k].dat !== d[k]) begin
                    bad++;
                    $display("FAIL cont_bus k=%0d got=cyc%0d/%0d/%0d exp=cyc%0d/%0d/%0d", k, bc_log[k].stamp - s,
                             bc_log[k].idx, bc_log[k].src, 2 + k, k + 1, k);
                end
            end
        end
        // rotation pointer must be back at 0: requester 0 beats requester 2
        bc_log.delete();
        pend[2].push_back('{3'd6, 32'hBBBB_0002});
        pend[0].push_back('{3'd4, 32'hAAAA_0000});
        pump(5);
        total++;
        if (bc_log.size() != 2 || bc_log[0].src !== REQ_ALU || bc_log[1].src !== REQ_BRU) begin
            bad++; $display("FAIL cont_rr_wrap got=n%0d exp=n2 order 0,2", bc_log.size());
        end
    endtask

    task automatic test_backpressure();
        int   first_lsb;
        ent_t alu_exp[$];
        ent_t lsb_exp[$];
        ent_t e;
        int   n_alu, n_lsb;
        bit   ok;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            e.idx = 3'($urandom); e.dat = $urandom;
            pend[0].push_back(e); alu_exp.push_back(e);
        end
        for (int i = 0; i < 3; i++) begin
            e.idx = 3'(4 + i); e.dat = 32'hCAFE_0000 + i;
            pend[1].push_back(e); lsb_exp.push_back(e);
        end
        pump(20);
        total++;
        if (rdy1_log[2] != 0) begin bad++; $display("FAIL bp_ready_drop got=%0d exp=0", rdy1_log[2]); end
        total++;
        if (acc1_log.size() != 3) begin
            bad++; $display("FAIL bp_accepts got=%0d exp=3", acc1_log.size());
        end else begin
            first_lsb = -1;
            foreach (bc_log[k]) if (first_lsb < 0 && bc_log[k].src == REQ_LSB) first_lsb = bc_log[k].stamp;
            total++;
            if (first_lsb < 0 || acc1_log[2] < first_lsb) begin
                bad++; $display("FAIL bp_third_after_pop got=acc%0d exp>=pop%0d", acc1_log[2], first_lsb);
            end
        end
        n_alu = 0; n_lsb = 0; ok = 1'b1;
        foreach (bc_log[k]) begin
            if (bc_log[k].src == REQ_ALU) begin
                if (n_alu >= 6 || {bc_log[k].idx, bc_log[k].dat} !== alu_exp[n_alu]) ok = 1'b0;
                n_alu++;
            end else if (bc_log[k].src == REQ_LSB) begin
                if (n_lsb >= 3 || {bc_log[k].idx, bc_log[k].dat} !== lsb_exp[n_lsb]) ok = 1'b0;
                n_lsb++;
            end else ok = 1'b0;
        end
        total++;
        if (!ok || n_alu != 6 || n_lsb != 3) begin
            bad++; $display("FAIL bp_order got=alu%0d lsb%0d ok%0d exp=alu6 lsb3 ok1", n_alu, n_lsb, ok);
        end
    endtask

    task automatic test_flush();
        int s;
        do_reset();
        for (int i = 0; i < N; i++) begin
            pend[i].push_back('{3'(i), 32'h1000 + i});
            pend[i].push_back('{3'(i + 3), 32'h2000 + i});
        end
        pump(2);
        flush_signal = 1'b1;
        req_valid = 3'b111; req_index = 9'h1FF; req_data = {3{32'hDEAD_BEEF}};
        @(negedge clk);
        total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL flush_ready got=%b exp=000", req_ready); end
        cyc();
        flush_signal = 1'b0; req_valid = '0;
        @(negedge clk);
        total++; if (CDB_update_en !== 1'b0) begin bad++; $display("FAIL flush_en got=%b exp=0", CDB_update_en); end
        total++; if (req_ready !== 3'b111) begin bad++; $display("FAIL flush_empty got=%b exp=111", req_ready); end
        cyc();
        bc_log.delete();
        pend[0].push_back('{3'd7, 32'h0000_7777});
        s = cyc_cnt;
        pump(6);
        total++;
        if (bc_log.size() != 1 || bc_log[0].idx !== 3'd7 || bc_log[0].src !== REQ_ALU || bc_log[0].stamp != s + 2) begin
            bad++; $display("FAIL flush_after got=n%0d exp=n1 idx7 src0 at cyc+2", bc_log.size());
        end
    endtask

    task automatic test_pause();
        int s;
        do_reset();
        for (int i = 0; i < N; i++) pend[i].push_back('{3'(i + 1), 32'h5000 + i});
        pump(1);
        cyc();
        rdy_in = 1'b0;
        for (int c = 0; c < 4; c++) begin
            flush_signal = (c == 1);
            @(negedge clk);
            total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL pause_ready c=%0d got=%b exp=000", c, req_ready); end
            if (c > 0) begin
                total++; if (CDB_update_en !== 1'b0) begin bad++; $display("FAIL pause_en c=%0d got=%b exp=0", c, CDB_update_en); end
            end
            cyc();
        end
        flush_signal = 1'b0;
        rdy_in = 1'b1;
        bc_log.delete();
        s = cyc_cnt;
        repeat (4) cyc();
        total++;
        if (bc_log.size() != 2 || bc_log[0].src !== REQ_LSB || bc_log[0].idx !== 3'd2 || bc_log[0].stamp != s + 1
            || bc_log[1].src !== REQ_BRU || bc_log[1].idx !== 3'd3) begin
            bad++; $display("FAIL pause_resume got=n%0d exp=n2 src1 then src2", bc_log.size());
        end
    endtask

    task automatic test_random();
        do_reset();
        bc_log.delete();
        for (int c = 0; c < 400; c++) begin
            rdy_in       = ($urandom_range(0, 9) != 0);
            flush_signal = ($urandom_range(0, 29) == 0);
            req_valid    = 3'($urandom);
            for (int i = 0; i < N; i++) begin
                req_index[i*RW +: RW] = 3'($urandom);
                req_data[i*32 +: 32]  = $urandom;
            end
            if (c == 200) begin
                #2 rst_in = 1'b0;
                #1;
                total++;
                if ({CDB_update_en, CDB_update_index, CDB_update_data, CDB_update_src} !== '0) begin
                    bad++; $display("FAIL async_rst got=%b/%0d/%h/%0d exp=0", CDB_update_en,
                                    CDB_update_index, CDB_update_data, CDB_update_src);
                end
                cyc();
                rst_in = 1'b1;
            end else begin
                cyc();
            end
        end
        rdy_in = 1'b1; flush_signal = 1'b0; req_valid = '0;
        repeat (6) cyc();
        total++;
        if (bc_log.size() < 30) begin bad++; $display("FAIL rand_activity got=%0d exp>=30", bc_log.size()); end
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; flush_signal = 1'b0;
        req_valid = '0; req_index = '0; req_data = '0;
        #1;
        test_reset();
        mon_on = 1'b1;
        test_single();
        test_contention();
        test_backpressure();
        test_flush();
        test_pause();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
